// File: rtl/cmp_minmax_scan_pkg.sv
// Shared types for the min/max stream scanner: comparator result codes,
// FSM state encoding and a small helper for the input-ready decode.
package cmp_minmax_scan_pkg;

  typedef enum logic [1:0] {
    OP1_EQ_OP2 = 2'd0,
    OP1_GT_OP2 = 2'd1,
    OP1_LT_OP2 = 2'd2
  } cmp_res_e;

  typedef enum logic [2:0] {
    SCAN_IDLE    = 3'd0,
    SCAN_WAIT    = 3'd1,
    SCAN_CMP_MAX = 3'd2,
    SCAN_CMP_MIN = 3'd3,
    SCAN_DONE    = 3'd4
  } scan_state_e;

  // The producer side is open only in the states that can take a word.
  function automatic logic scan_accepts(input scan_state_e s);
    return (s == SCAN_IDLE) || (s == SCAN_WAIT);
  endfunction

endpackage

// File: rtl/cmp_minmax_scan_if.sv
// Producer stream and result handshake of the min/max scanner.
interface cmp_minmax_scan_if #(parameter int IDX_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_data;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic [63:0]       max_val;
  logic [IDX_W-1:0]  max_idx;
  logic [63:0]       min_val;
  logic [IDX_W-1:0]  min_idx;
  logic [IDX_W:0]    count;
  logic              ovf;

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, max_val, max_idx, min_val, min_idx, count, ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, max_val, max_idx, min_val, min_idx, count, ovf
  );
endinterface

// File: rtl/cmp_minmax_scan_cmp64u.sv
// Unsigned 64-bit three-way comparator, shared between the max and min passes.
module cmp_minmax_scan_cmp64u
  import cmp_minmax_scan_pkg::*;
(
  input  logic [63:0] op1_i,
  input  logic [63:0] op2_i,
  output cmp_res_e    res_o
);

  // Three-way unsigned compare.
  always_comb begin
    if (op1_i > op2_i) begin
      res_o = OP1_GT_OP2;
    end else if (op1_i < op2_i) begin
      res_o = OP1_LT_OP2;
    end else begin
      res_o = OP1_EQ_OP2;
    end
  end

endmodule

// File: rtl/cmp_minmax_scan.sv
// Frame-wise min/max finder over unsigned 64-bit words using one time-shared
// comparator (max pass, then min pass) per element; result held until taken.
module cmp_minmax_scan
  import cmp_minmax_scan_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  cmp_minmax_scan_if.slave bus_if
);

  localparam logic [IDX_W:0] COUNT_FULL = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] COUNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

  scan_state_e      state_q;
  scan_state_e      state_d;
  logic [63:0]      cur_q;
  logic             last_q;
  logic [63:0]      max_q;
  logic [63:0]      min_q;
  logic [IDX_W-1:0] max_idx_q;
  logic [IDX_W-1:0] min_idx_q;
  logic [IDX_W:0]   count_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             res_valid_q;

  logic             accept_s;
  logic             take_s;
  logic             full_s;
  logic [63:0]      op2_s;
  cmp_res_e         cmp_res_s;

  cmp_minmax_scan_cmp64u u_cmp (
    .op1_i (cur_q),
    .op2_i (op2_s),
    .res_o (cmp_res_s)
  );

  // Handshake decode, comparator operand select and next-state logic.
  always_comb begin
    accept_s = bus_if.in_valid && in_ready_q;
    take_s   = res_valid_q && bus_if.res_ready;
    full_s   = (count_q == COUNT_FULL);
    op2_s    = (state_q == SCAN_CMP_MIN) ? min_q : max_q;
    state_d  = state_q;
    case (state_q)
      SCAN_IDLE: begin
        if (accept_s) begin
          state_d = bus_if.in_last ? SCAN_DONE : SCAN_WAIT;
        end else begin
          state_d = SCAN_IDLE;
        end
      end
      SCAN_WAIT: begin
        // A word past the index range is dropped; only its in_last matters.
        if (accept_s && full_s) begin
          state_d = bus_if.in_last ? SCAN_DONE : SCAN_WAIT;
        end else if (accept_s) begin
          state_d = SCAN_CMP_MAX;
        end else begin
          state_d = SCAN_WAIT;
        end
      end
      SCAN_CMP_MAX: state_d = SCAN_CMP_MIN;
      SCAN_CMP_MIN: state_d = last_q ? SCAN_DONE : SCAN_WAIT;
      SCAN_DONE: begin
        if (take_s) begin
          state_d = SCAN_IDLE;
        end else begin
          state_d = SCAN_DONE;
        end
      end
      default: state_d = SCAN_IDLE;
    endcase
  end

  // FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SCAN_IDLE;
      cur_q       <= 64'd0;
      last_q      <= 1'b0;
      max_q       <= 64'd0;
      min_q       <= 64'd0;
      max_idx_q   <= '0;
      min_idx_q   <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= scan_accepts(state_d);
      res_valid_q <= (state_d == SCAN_DONE);
      case (state_q)
        SCAN_IDLE: begin
          if (accept_s) begin
            cur_q     <= bus_if.in_data;
            last_q    <= bus_if.in_last;
            max_q     <= bus_if.in_data;
            min_q     <= bus_if.in_data;
            max_idx_q <= '0;
            min_idx_q <= '0;
            count_q   <= COUNT_ONE;
            ovf_q     <= 1'b0;
          end
        end
        SCAN_WAIT: begin
          if (accept_s && full_s) begin
            ovf_q <= 1'b1;
          end else if (accept_s) begin
            cur_q  <= bus_if.in_data;
            last_q <= bus_if.in_last;
          end
        end
        SCAN_CMP_MAX: begin
          if (cmp_res_s == OP1_GT_OP2) begin
            max_q     <= cur_q;
            max_idx_q <= count_q[IDX_W-1:0];
          end
        end
        SCAN_CMP_MIN: begin
          if (cmp_res_s == OP1_LT_OP2) begin
            min_q     <= cur_q;
            min_idx_q <= count_q[IDX_W-1:0];
          end
          count_q <= count_q + COUNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus_if.in_ready  = in_ready_q;
  assign bus_if.res_valid = res_valid_q;
  assign bus_if.max_val   = max_q;
  assign bus_if.max_idx   = max_idx_q;
  assign bus_if.min_val   = min_q;
  assign bus_if.min_idx   = min_idx_q;
  assign bus_if.count     = count_q;
  assign bus_if.ovf       = ovf_q;

endmodule

// File: tb/tb_cmp_minmax_scan.sv
// Directed bench for cmp_minmax_scan: an IDX_W=8 instance for the main cases
// and an IDX_W=2 instance for overflow, selected by sel2.
module tb_cmp_minmax_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel2 = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic        in_last = 1'b0;
  logic        res_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_minmax_scan_if #(.IDX_W(8)) bus8 ();
  cmp_minmax_scan_if #(.IDX_W(2)) bus2 ();

  cmp_minmax_scan #(.IDX_W(8)) u_dut8 (.clk_i(clk), .rst_i(rst), .bus_if(bus8));
  cmp_minmax_scan #(.IDX_W(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus_if(bus2));

  assign bus8.in_valid  = in_valid & ~sel2;
  assign bus2.in_valid  = in_valid & sel2;
  assign bus8.in_data   = in_data;
  assign bus2.in_data   = in_data;
  assign bus8.in_last   = in_last;
  assign bus2.in_last   = in_last;
  assign bus8.res_ready = res_ready & ~sel2;
  assign bus2.res_ready = res_ready & sel2;

  logic        o_in_ready, o_res_valid, o_ovf;
  logic [63:0] o_max_val, o_min_val;
  logic [7:0]  o_max_idx, o_min_idx;
  logic [8:0]  o_count;

  assign o_in_ready  = sel2 ? bus2.in_ready  : bus8.in_ready;
  assign o_res_valid = sel2 ? bus2.res_valid : bus8.res_valid;
  assign o_ovf       = sel2 ? bus2.ovf       : bus8.ovf;
  assign o_max_val   = sel2 ? bus2.max_val   : bus8.max_val;
  assign o_min_val   = sel2 ? bus2.min_val   : bus8.min_val;
  assign o_max_idx   = sel2 ? {6'd0, bus2.max_idx} : bus8.max_idx;
  assign o_min_idx   = sel2 ? {6'd0, bus2.min_idx} : bus8.min_idx;
  assign o_count     = sel2 ? {6'd0, bus2.count}   : bus8.count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called and returns just after a falling edge; word is accepted at the rising edge in between.
  task automatic send_word(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!o_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", o_in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!o_res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("res_timeout", o_res_valid, 1'b1);
  endtask

  task automatic check_res(input string tag, input logic [63:0] mx, input logic [7:0] mxi,
                           input logic [63:0] mn, input logic [7:0] mni,
                           input logic [8:0] cnt, input logic ov);
    wait_res();
    chk({tag, "_max"},    o_max_val, mx);
    chk({tag, "_maxidx"}, o_max_idx, mxi);
    chk({tag, "_min"},    o_min_val, mn);
    chk({tag, "_minidx"}, o_min_idx, mni);
    chk({tag, "_count"},  o_count, cnt);
    chk({tag, "_ovf"},    o_ovf, ov);
    chk({tag, "_rdy"},    o_in_ready, 1'b0);
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_rv_clr"}, o_res_valid, 1'b0);
    chk({tag, "_idle_rdy"}, o_in_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy", o_in_ready, 1'b0);
    chk("rst_rv", o_res_valid, 1'b0);
    chk("rst_max", o_max_val, 64'd0);
    chk("rst_count", o_count, 9'd0);
    rst = 1'b0;
    chk("post_rst_rdy0", o_in_ready, 1'b0);
    @(negedge clk);
    chk("post_rst_rdy1", o_in_ready, 1'b1);

    // Basic frame with latency check
    send_word(64'd5, 1'b0);
    send_word(64'd9, 1'b0);
    send_word(64'd3, 1'b0);
    send_word(64'd9, 1'b0);
    send_word(64'd1, 1'b1);
    chk("basic_lat0", o_res_valid, 1'b0);
    @(negedge clk);
    chk("basic_lat1", o_res_valid, 1'b0);
    @(negedge clk);
    chk("basic_lat2", o_res_valid, 1'b1);
    check_res("basic", 64'd9, 8'd1, 64'd1, 8'd4, 9'd5, 1'b0);
    consume("basic");

    // Single element frame
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("single_lat", o_res_valid, 1'b1);
    check_res("single", 64'hFFFF_FFFF_FFFF_FFFF, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0, 9'd1, 1'b0);
    consume("single");

    // Unsigned ordering
    send_word(64'h8000_0000_0000_0000, 1'b0);
    send_word(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    check_res("unsigned", 64'h8000_0000_0000_0000, 8'd0, 64'h7FFF_FFFF_FFFF_FFFF, 8'd1, 9'd2, 1'b0);
    consume("unsigned");

    // Backpressure: result held while res_ready low
    send_word(64'd10, 1'b0);
    send_word(64'd20, 1'b1);
    wait_res();
    for (int i = 0; i < 10; i++) begin
      chk("bp_rv", o_res_valid, 1'b1);
      chk("bp_rdy", o_in_ready, 1'b0);
      chk("bp_max", o_max_val, 64'd20);
      chk("bp_min", o_min_val, 64'd10);
      @(negedge clk);
    end
    consume("bp");

    // Reset mid-frame
    send_word(64'd7, 1'b0);
    send_word(64'd3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", o_in_ready, 1'b0);
    chk("midrst_rv", o_res_valid, 1'b0);
    chk("midrst_max", o_max_val, 64'd0);
    chk("midrst_min", o_min_val, 64'd0);
    chk("midrst_count", o_count, 9'd0);
    rst = 1'b0;
    @(negedge clk);
    send_word(64'd4, 1'b0);
    send_word(64'd2, 1'b1);
    check_res("afterrst", 64'd4, 8'd0, 64'd2, 8'd1, 9'd2, 1'b0);
    consume("afterrst");

    // Overflow on the IDX_W=2 instance
    sel2 = 1'b1;
    @(negedge clk);
    send_word(64'd1, 1'b0);
    send_word(64'd2, 1'b0);
    send_word(64'd3, 1'b0);
    send_word(64'd4, 1'b0);
    send_word(64'd9, 1'b0);
    chk("ovf_stay_wait", o_in_ready, 1'b1);
    send_word(64'd0, 1'b1);
    chk("ovf_lat", o_res_valid, 1'b1);
    check_res("ovf", 64'd4, 8'd3, 64'd1, 8'd0, 9'd4, 1'b1);
    consume("ovf");
    send_word(64'd6, 1'b1);
    check_res("ovf_clear", 64'd6, 8'd0, 64'd6, 8'd0, 9'd1, 1'b0);
    consume("ovf_clear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
